// File: rtl/fp32_mac_vec.sv
// Streaming FP32 dot-product engine: delta = acc + sum(alpha[k]*bravo[k]) over VEC_LEN pairs.
// Optional macro FP32_MAC_RELU_EN clamps negative-signed results to +0 in DRAIN.

module FP32_Multiplier_Combinatorial (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic              sign, g, s;
   logic [7:0]        ea, eb;
   logic [47:0]       prod;
   logic signed [9:0] e;
   logic [22:0]       f;
   logic [23:0]       r;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   // Denormal inputs are flushed to zero; rounding is nearest-even.
   always_comb begin
      sign   = a[31] ^ b[31];
      ea     = a[30:23];
      eb     = b[30:23];
      a_nan  = (ea == 8'hFF) && (|a[22:0]);
      b_nan  = (eb == 8'hFF) && (|b[22:0]);
      a_inf  = (ea == 8'hFF) && !(|a[22:0]);
      b_inf  = (eb == 8'hFF) && !(|b[22:0]);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (prod[47]) begin
         f = prod[46:24];
         g = prod[23];
         s = |prod[22:0];
         e = e + 10'sd1;
      end else begin
         f = prod[45:23];
         g = prod[22];
         s = |prod[21:0];
      end
      r = {1'b0, f} + {23'b0, g & (s | f[0])};
      if (r[23]) begin
         f = 23'b0;
         e = e + 10'sd1;
      end else begin
         f = r[22:0];
      end
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y = 32'h7FC0_0000;
      else if (a_inf || b_inf)                                        y = {sign, 8'hFF, 23'b0};
      else if (a_zero || b_zero)                                      y = {sign, 31'b0};
      else if (e >= 10'sd255)                                         y = {sign, 8'hFF, 23'b0};
      else if (e <= 10'sd0)                                           y = {sign, 31'b0};
      else                                                            y = {sign, e[7:0], f};
   end
endmodule

module FP32_Adder_Combinatorial (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic              swap, sl, ss, g, s;
   logic [7:0]        el, es, shift;
   logic [22:0]       fl, fs, f;
   logic [49:0]       big, sml, sum;
   logic [48:0]       n;
   logic [5:0]        p;
   logic signed [9:0] e;
   logic [23:0]       r;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   // Sum is exact in 50 bits for alignment shifts below 26; larger shifts leave the bigger operand.
   always_comb begin
      a_nan  = (a[30:23] == 8'hFF) && (|a[22:0]);
      b_nan  = (b[30:23] == 8'hFF) && (|b[22:0]);
      a_inf  = (a[30:23] == 8'hFF) && !(|a[22:0]);
      b_inf  = (b[30:23] == 8'hFF) && !(|b[22:0]);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      swap   = b[30:0] > a[30:0];
      {sl, el, fl} = swap ? b : a;
      {ss, es, fs} = swap ? a : b;
      shift  = el - es;
      big    = {2'b01, fl, 25'b0};
      sml    = {2'b01, fs, 25'b0} >> shift;
      sum    = (sl ^ ss) ? big - sml : big + sml;
      p      = 6'd0;
      for (int i = 0; i < 50; i++) if (sum[i]) p = 6'(i);
      e      = $signed({2'b00, el}) + $signed({4'b0000, p}) - 10'sd48;
      n      = sum[48:0] << (6'd49 - p);
      f      = n[48:26];
      g      = n[25];
      s      = |n[24:0];
      r      = {1'b0, f} + {23'b0, g & (s | f[0])};
      if (r[23]) begin
         f = 23'b0;
         e = e + 10'sd1;
      end else begin
         f = r[22:0];
      end
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = 32'h7FC0_0000;
      else if (a_inf)             y = {a[31], 8'hFF, 23'b0};
      else if (b_inf)             y = {b[31], 8'hFF, 23'b0};
      else if (a_zero && b_zero)  y = {a[31] & b[31], 31'b0};
      else if (a_zero)            y = b;
      else if (b_zero)            y = a;
      else if (shift >= 8'd26)    y = {sl, el, fl};
      else if (sum == 50'b0)      y = 32'h0000_0000;
      else if (e >= 10'sd255)     y = {sl, 8'hFF, 23'b0};
      else if (e <= 10'sd0)       y = {sl, 31'b0};
      else                        y = {sl, e[7:0], f};
   end
endmodule

module fp32_mac_vec #(
   parameter int VEC_LEN = 4,
   parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
   input  logic        CLK_I,
   input  logic        RSTL_I,
   input  logic [31:0] alpha,
   input  logic [31:0] bravo,
   input  logic [31:0] acc,
   input  logic        MAC_VALID_I,
   output logic        MAC_READY_O,
   output logic [31:0] delta,
   output logic        MAC_VALID_O,
   input  logic        MAC_READY_I
);
   // Input accepted on MAC_VALID_I && MAC_READY_O; result taken on MAC_VALID_O && MAC_READY_I,
   // both at a rising CLK_I edge; delta is held stable while MAC_VALID_O waits for MAC_READY_I.
   typedef enum logic [1:0] {ST_RST, ST_ACCUM, ST_DRAIN, ST_OUT} state_t;

   state_t            state, state_nxt;
   logic              ready_nxt, valid_nxt;
   logic [31:0]       prod_reg, acc_reg, mul_y, add_y, drain_val;
   logic              prod_v;
   logic [CNT_W-1:0]  elem_cnt;
   logic              accept, first, last, out_take;

   FP32_Multiplier_Combinatorial u_mul (.a(alpha),   .b(bravo),    .y(mul_y));
   FP32_Adder_Combinatorial      u_add (.a(acc_reg), .b(prod_reg), .y(add_y));

`ifdef FP32_MAC_RELU_EN
   assign drain_val = add_y[31] ? 32'h0000_0000 : add_y;
`else
   assign drain_val = add_y;
`endif

   assign accept   = MAC_VALID_I && MAC_READY_O && (state == ST_ACCUM);
   assign first    = accept && (elem_cnt == '0);
   assign last     = accept && (elem_cnt == CNT_W'(VEC_LEN - 1));
   assign out_take = MAC_VALID_O && MAC_READY_I;

   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
         state       <= ST_RST;
         MAC_READY_O <= 1'b0;
         MAC_VALID_O <= 1'b0;
      end else begin
         state       <= state_nxt;
         MAC_READY_O <= ready_nxt;
         MAC_VALID_O <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready_nxt = MAC_READY_O;
      valid_nxt = MAC_VALID_O;
      case (state)
         ST_RST: begin
            state_nxt = ST_ACCUM;
            ready_nxt = 1'b1;
         end
         ST_ACCUM: if (last) begin
            state_nxt = ST_DRAIN;
            ready_nxt = 1'b0;
         end
         ST_DRAIN: begin
            state_nxt = ST_OUT;
            valid_nxt = 1'b1;
         end
         ST_OUT: if (out_take) begin
            state_nxt = ST_ACCUM;
            valid_nxt = 1'b0;
            ready_nxt = 1'b1;
         end
         default: state_nxt = ST_RST;
      endcase
   end

   // A pending product is folded in on the next edge unless a new vector's bias is loading.
   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
         prod_reg <= 32'h0;
         prod_v   <= 1'b0;
         acc_reg  <= 32'h0;
         elem_cnt <= '0;
         delta    <= 32'h0;
      end else if (state == ST_ACCUM) begin
         if (accept) begin
            prod_reg <= mul_y;
            prod_v   <= 1'b1;
            elem_cnt <= elem_cnt + 1'b1;
         end else begin
            prod_v   <= 1'b0;
         end
         if (first)       acc_reg <= acc;
         else if (prod_v) acc_reg <= add_y;
      end else if (state == ST_DRAIN) begin
         delta    <= drain_val;
         prod_v   <= 1'b0;
         elem_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_fp32_mac_vec.sv
// Directed bench for fp32_mac_vec: one VEC_LEN=4 and one VEC_LEN=1 instance on a shared clock/reset.
// Expected ReLU result follows FP32_MAC_RELU_EN.

module tb_fp32_mac_vec;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alpha4, bravo4, acc4, delta4;
   logic        vi4, ro4, vo4, ri4;
   logic [31:0] alpha1, bravo1, acc1, delta1;
   logic        vi1, ro1, vo1, ri1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

`ifdef FP32_MAC_RELU_EN
   localparam logic [31:0] RELU_EXP = 32'h0000_0000;
`else
   localparam logic [31:0] RELU_EXP = 32'hBEC0_0000;
`endif

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   fp32_mac_vec #(.VEC_LEN(4)) u_dut4 (
      .CLK_I(clk), .RSTL_I(rst_n), .alpha(alpha4), .bravo(bravo4), .acc(acc4),
      .MAC_VALID_I(vi4), .MAC_READY_O(ro4), .delta(delta4), .MAC_VALID_O(vo4), .MAC_READY_I(ri4)
   );

   fp32_mac_vec #(.VEC_LEN(1)) u_dut1 (
      .CLK_I(clk), .RSTL_I(rst_n), .alpha(alpha1), .bravo(bravo1), .acc(acc1),
      .MAC_VALID_I(vi1), .MAC_READY_O(ro1), .delta(delta1), .MAC_VALID_O(vo1), .MAC_READY_I(ri1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, req);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic req);
      n_checks++;
      assert (obs === req) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, req);
      end
   endtask

   // driver tasks: entered and left at a falling edge
   task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      int n = 0;
      alpha4 = a; bravo4 = b; acc4 = c; vi4 = 1'b1;
      while (!ro4 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check1("send4_ready", ro4, 1'b1);
      @(negedge clk);
      vi4 = 1'b0;
   endtask

   task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      int n = 0;
      alpha1 = a; bravo1 = b; acc1 = c; vi1 = 1'b1;
      while (!ro1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check1("send1_ready", ro1, 1'b1);
      @(negedge clk);
      vi1 = 1'b0;
   endtask

   task automatic wait_valid4();
      int n = 0;
      while (!vo4 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check1("vo4_timeout", vo4, 1'b1);
   endtask

   // scoreboard: compare the result at the handshake against the queue head
   task automatic take4(input string tag);
      exp_v = exp_q.pop_front();
      wait_valid4();
      check(tag, delta4, exp_v);
      @(negedge clk);
      check1({tag, "_vo_drop"}, vo4, 1'b0);
      check1({tag, "_ro_back"}, ro4, 1'b1);
   endtask

   task automatic take1(input string tag);
      int n = 0;
      exp_v = exp_q.pop_front();
      while (!vo1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check1({tag, "_valid"}, vo1, 1'b1);
      check(tag, delta1, exp_v);
      @(negedge clk);
      check1({tag, "_vo_drop"}, vo1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      alpha4 = '0; bravo4 = '0; acc4 = '0; vi4 = 1'b0; ri4 = 1'b1;
      alpha1 = '0; bravo1 = '0; acc1 = '0; vi1 = 1'b0; ri1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check1("rst_ro4", ro4, 1'b0);
      check1("rst_vo4", vo4, 1'b0);
      check("rst_delta4", delta4, 32'h0);
      check1("rst_ro1", ro1, 1'b0);
      check1("rst_vo1", vo1, 1'b0);
      check("rst_delta1", delta1, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check1("post_rst_ro4", ro4, 1'b1);
      check1("post_rst_ro1", ro1, 1'b1);

      // basic dot product 1+2+3+4 = 10, plus latency
      exp_q.push_back(32'h4120_0000);
      send4(32'h3F80_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4000_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4040_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4080_0000, 32'h3F80_0000, 32'h0);
      check1("lat_edge_t", vo4, 1'b0);
      check1("lat_ro_low", ro4, 1'b0);
      @(negedge clk);
      check1("lat_edge_t1", vo4, 1'b1);
      check1("lat_ro_low2", ro4, 1'b0);
      take4("dot_basic");

      // bias and sign cases on the single-element instance
      exp_q.push_back(32'h3E00_0000);
      send1(32'hBF00_0000, 32'h3F40_0000, 32'h3F00_0000);
      take1("bias");
      exp_q.push_back(RELU_EXP);
      send1(32'hBF00_0000, 32'h3F40_0000, 32'h0);
      take1("relu");

      // bubbles between elements and a 10-cycle output stall
      ri4 = 1'b0;
      exp_q.push_back(32'h4120_0000);
      send4(32'h3F80_0000, 32'h3F80_0000, 32'h0);
      repeat (3) @(negedge clk);
      send4(32'h4000_0000, 32'h3F80_0000, 32'h0);
      repeat (3) @(negedge clk);
      send4(32'h4040_0000, 32'h3F80_0000, 32'h0);
      repeat (3) @(negedge clk);
      send4(32'h4080_0000, 32'h3F80_0000, 32'h0);
      exp_v = exp_q.pop_front();
      wait_valid4();
      check("bubble_dot", delta4, exp_v);
      alpha4 = 32'h3F80_0000; bravo4 = 32'h4000_0000; acc4 = 32'h3F80_0000; vi4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_delta", delta4, exp_v);
         check1("stall_vo", vo4, 1'b1);
         check1("stall_ro", ro4, 1'b0);
      end
      ri4 = 1'b1;
      @(negedge clk);
      check1("stall_release_vo", vo4, 1'b0);
      check1("stall_release_ro", ro4, 1'b1);
      exp_q.push_back(32'h4110_0000);
      send4(32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000);
      send4(32'h3F80_0000, 32'h4000_0000, 32'h0);
      send4(32'h3F80_0000, 32'h4000_0000, 32'h0);
      send4(32'h3F80_0000, 32'h4000_0000, 32'h0);
      take4("dot_after_stall");

      // reset in the middle of a vector
      send4(32'h3F80_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4000_0000, 32'h3F80_0000, 32'h0);
      rst_n = 1'b0;
      #1;
      check1("mid_rst_ro4", ro4, 1'b0);
      check1("mid_rst_vo4", vo4, 1'b0);
      check("mid_rst_delta4", delta4, 32'h0);
      @(negedge clk);
      check1("mid_rst_ro4_hold", ro4, 1'b0);
      check("mid_rst_delta4_hold", delta4, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check1("mid_rst_ro4_up", ro4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check1("no_partial_result", vo4, 1'b0);
      end
      exp_q.push_back(32'h4120_0000);
      send4(32'h3F80_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4000_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4040_0000, 32'h3F80_0000, 32'h0);
      send4(32'h4080_0000, 32'h3F80_0000, 32'h0);
      take4("dot_after_rst");

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
